// File: rtl/panda_fetch_ctrl.sv
// Panda instruction-fetch sequencer: single-outstanding req/gnt/rvalid port, redirects, one-entry decode buffer.
// Define PANDA_FETCH_PERF_EN to build the fetch/flush performance counters.
module panda_fetch_ctrl #(
  parameter int unsigned      Width    = 32,
  parameter logic [Width-1:0] BootAddr = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             branch_i,
  input  logic [Width-1:0] branch_target_i,
  input  logic             jump_i,
  input  logic [Width-1:0] jump_target_i,
  output logic             instr_req_o,
  output logic [Width-1:0] instr_addr_o,
  input  logic             instr_gnt_i,
  input  logic             instr_rvalid_i,
  input  logic [Width-1:0] instr_rdata_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [Width-1:0] instr_o,
  output logic [Width-1:0] instr_pc_o,
  output logic [Width-1:0] pc_inc_o,
  output logic [31:0]      fetch_cnt_o,
  output logic [31:0]      flush_cnt_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] fetch_pc_q, fetch_pc_d;
  logic [Width-1:0] instr_q, instr_d;
  logic [Width-1:0] instr_pc_q, instr_pc_d;
  logic [Width-1:0] pc_inc_q, pc_inc_d;
  logic             buf_valid_q, buf_valid_d;

  logic             redirect;
  logic [Width-1:0] redirect_sel;
  logic [Width-1:0] target;
  logic             req_fire;
  logic             load;

  assign redirect     = jump_i | branch_i;
  assign redirect_sel = jump_i ? jump_target_i : branch_target_i;
  assign target       = redirect_sel & ~(Width'(3));
  assign req_fire     = instr_req_o & instr_gnt_i;
  assign load         = (state_q == WAIT) & instr_rvalid_i & ~redirect;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A redirect never cancels an accepted request; its response must still be drained in DISCARD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (req_fire) state_d = redirect ? DISCARD : WAIT;
      WAIT:    if (instr_rvalid_i) state_d = REQ;
               else if (redirect)  state_d = DISCARD;
      DISCARD: if (instr_rvalid_i) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_req_o  = (state_q == REQ) & (~buf_valid_q | instr_ready_i);
    instr_addr_o = fetch_pc_q;
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    pc_inc_d    = pc_inc_q;
    buf_valid_d = buf_valid_q;
    if (redirect)  fetch_pc_d = target;
    else if (load) fetch_pc_d = fetch_pc_q + Width'(4);
    if (load) begin
      instr_d    = instr_rdata_i;
      instr_pc_d = fetch_pc_q;
      pc_inc_d   = fetch_pc_q + Width'(4);
    end
    if (redirect)           buf_valid_d = 1'b0;
    else if (load)          buf_valid_d = 1'b1;
    else if (instr_ready_i) buf_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q  <= BootAddr;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      pc_inc_q    <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      pc_inc_q    <= pc_inc_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  assign instr_valid_o = buf_valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign pc_inc_o      = pc_inc_q;

`ifdef PANDA_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        drop;

  assign drop = instr_rvalid_i & ((state_q == DISCARD) | ((state_q == WAIT) & redirect));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (drop) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign fetch_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_panda_fetch_ctrl.sv
// Self-checking bench for panda_fetch_ctrl: directed plan scenarios plus randomized traffic
// compared every cycle against a transaction-level model (outstanding/drop flags, buffer slot).
module tb_panda_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        branch = 1'b0, jump = 1'b0;
  logic [31:0] branchTarget = '0, jumpTarget = '0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        gnt = 1'b0, rvalid = 1'b0, ready = 1'b0;
  logic [31:0] rdata = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o, instr_pc_o, pc_inc_o, fetch_cnt_o, flush_cnt_o;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  panda_fetch_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .branch_i(branch), .branch_target_i(branchTarget),
    .jump_i(jump), .jump_target_i(jumpTarget),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(gnt), .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
    .instr_valid_o(instr_valid_o), .instr_ready_i(ready),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .pc_inc_o(pc_inc_o),
    .fetch_cnt_o(fetch_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  function automatic logic [31:0] dataFor(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: fetch PC, one outstanding flag, whether that response is doomed, buffer slot.
  bit          mStarted, mOut, mDrop, mBufValid;
  logic [31:0] mPc, mBufPc, mBufInstr;
  int unsigned mFetch, mFlush;

  function automatic logic [31:0] expCnt(input int unsigned v);
`ifdef PANDA_FETCH_PERF_EN
    return v;
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      mStarted = 0; mOut = 0; mDrop = 0; mBufValid = 0;
      mPc = 32'h0; mBufPc = 0; mBufInstr = 0; mFetch = 0; mFlush = 0;
      checkOutput("rstReq", {31'b0, instr_req_o}, 32'd0);
      checkOutput("rstAddr", instr_addr_o, 32'h0);
      checkOutput("rstValid", {31'b0, instr_valid_o}, 32'd0);
      checkOutput("rstInstr", instr_o, 32'd0);
      checkOutput("rstPc", instr_pc_o, 32'd0);
      checkOutput("rstPcInc", pc_inc_o, 32'd0);
      checkOutput("rstFetchCnt", fetch_cnt_o, 32'd0);
      checkOutput("rstFlushCnt", flush_cnt_o, 32'd0);
    end else begin
      bit          expReq, redir, loaded;
      logic [31:0] tgt;
      expReq = mStarted && !mOut && (!mBufValid || ready);
      checkOutput("req", {31'b0, instr_req_o}, {31'b0, expReq});
      checkOutput("addr", instr_addr_o, mPc);
      checkOutput("valid", {31'b0, instr_valid_o}, {31'b0, mBufValid});
      if (mBufValid) begin
        checkOutput("instr", instr_o, mBufInstr);
        checkOutput("instrPc", instr_pc_o, mBufPc);
        checkOutput("pcInc", pc_inc_o, mBufPc + 32'd4);
      end
      checkOutput("fetchCnt", fetch_cnt_o, expCnt(mFetch));
      checkOutput("flushCnt", flush_cnt_o, expCnt(mFlush));

      redir  = jump | branch;
      tgt    = jump ? jumpTarget : branchTarget;
      tgt    = {tgt[31:2], 2'b00};
      loaded = 0;
      if (!mStarted) mStarted = 1;
      else if (!mOut) begin
        if (expReq && gnt) begin mOut = 1; mDrop = redir; end
      end else if (rvalid) begin
        mOut = 0;
        if (mDrop || redir) mFlush++;
        else begin
          loaded = 1; mBufPc = mPc; mBufInstr = rdata; mFetch++; mPc = mPc + 32'd4;
        end
        mDrop = 0;
      end else if (redir) mDrop = 1;
      if (redir) mPc = tgt;
      if (redir)       mBufValid = 0;
      else if (loaded) mBufValid = 1;
      else if (ready)  mBufValid = 0;
    end
  end

  // Bench-side memory: remembers the one granted address so it can return matching data.
  bit          drvOut = 0;
  logic [31:0] drvAddr = '0;
  logic [31:0] grantLog[$];
  logic [31:0] pcLog[$];

  // rvMode: 0 = no response, 1 = respond if a request is outstanding, 2 = stray rvalid.
  task automatic applyStimulus(input bit r, input bit rdy, input bit br, input logic [31:0] bt,
                               input bit jp, input logic [31:0] jt, input bit gntEn, input int rvMode);
    @(posedge clk);
    #1;
    rst = r; ready = rdy; branch = br; branchTarget = bt; jump = jp; jumpTarget = jt;
    gnt = 0; rvalid = 0; rdata = $urandom;
    if (r) drvOut = 0;
    if (!r && rvMode == 1 && drvOut) begin
      rvalid = 1; rdata = dataFor(drvAddr); drvOut = 0;
    end else if (!r && rvMode == 2 && !drvOut) rvalid = 1;
    #1;
    if (!r && gntEn && instr_req_o) begin
      gnt = 1; drvOut = 1; drvAddr = instr_addr_o; grantLog.push_back(instr_addr_o);
    end
  endtask

  initial begin
    #1 rst = 1;
    repeat (3) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("bootAddr", instr_addr_o, 32'h0);
    grantLog.delete();

    for (int c = 0; c < 40 && grantLog.size() < 4; c++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 1);
      if (instr_valid_o) pcLog.push_back(instr_pc_o);
    end
    checkOutput("grantCount", grantLog.size(), 32'd4);
    for (int i = 0; i < 4 && i < grantLog.size(); i++)
      checkOutput("grantAddrSeq", grantLog[i], 32'(4 * i));
    checkOutput("pcLogCount", pcLog.size(), 32'd3);
    for (int i = 0; i < 3 && i < pcLog.size(); i++)
      checkOutput("instrPcSeq", pcLog[i], 32'(4 * i));
    checkOutput("pcIncLit", pc_inc_o, 32'd12);
    checkOutput("instrLit", instr_o, dataFor(32'd8));
    checkOutput("fetchCntLit", fetch_cnt_o, expCnt(3));

    // Decode stalls: the response for 12 lands, then everything must hold.
    for (int c = 0; c < 6; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
      if (c >= 1) begin
        checkOutput("holdValid", {31'b0, instr_valid_o}, 32'd1);
        checkOutput("holdPc", instr_pc_o, 32'd12);
        checkOutput("holdInstr", instr_o, dataFor(32'd12));
        checkOutput("holdReq", {31'b0, instr_req_o}, 32'd0);
      end
    end
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
    checkOutput("resumeReq", {31'b0, instr_req_o}, 32'd1);
    checkOutput("resumeAddr", instr_addr_o, 32'd16);

    // Branch to 24 in WAIT with the response arriving the same cycle: it is dropped.
    applyStimulus(0, 1, 1, 32'd24, 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 32'd24, 1, 32'd56, 0, 0);
    checkOutput("branchAddr", instr_addr_o, 32'd24);
    checkOutput("branchValid", {31'b0, instr_valid_o}, 32'd0);
    checkOutput("branchFlush", flush_cnt_o, expCnt(1));
    applyStimulus(0, 1, 0, 0, 1, 32'h3A, 0, 0);
    checkOutput("jumpPrioAddr", instr_addr_o, 32'd56);
    checkOutput("jumpFlush", flush_cnt_o, expCnt(1));
    applyStimulus(0, 1, 0, 0, 1, 32'hFFFF_FFFE, 0, 0);
    checkOutput("alignAddr", instr_addr_o, 32'h38);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
    checkOutput("topAddr", instr_addr_o, 32'hFFFF_FFFC);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("wrapAddr", instr_addr_o, 32'h0);
    checkOutput("wrapPc", instr_pc_o, 32'hFFFF_FFFC);
    checkOutput("wrapPcInc", pc_inc_o, 32'h0);

    // Reset in WAIT, then a stray rvalid after release.
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
    checkOutput("preRstAddr", instr_addr_o, 32'd4);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("midRstAddr", instr_addr_o, 32'h0);
    checkOutput("midRstReq", {31'b0, instr_req_o}, 32'd0);
    checkOutput("midRstValid", {31'b0, instr_valid_o}, 32'd0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 2);
    checkOutput("strayReq", {31'b0, instr_req_o}, 32'd0);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
    checkOutput("postRstReq", {31'b0, instr_req_o}, 32'd1);
    checkOutput("postRstAddr", instr_addr_o, 32'h0);
    checkOutput("postRstValid", {31'b0, instr_valid_o}, 32'd0);

    for (int c = 0; c < 4000; c++) begin
      bit r;
      int rv;
      r  = ($urandom_range(0, 199) == 0);
      rv = ($urandom_range(0, 2) != 0) ? 1 : (($urandom_range(0, 9) == 0) ? 2 : 0);
      applyStimulus(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), $urandom,
                    ($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 2) != 0), rv);
    end
    repeat (4) applyStimulus(0, 1, 0, 0, 0, 0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
